// File: rtl/shifter_pkg.sv
// Shared mode encodings and helpers for the pipelined barrel shifter.
// Imported by every stage and by the top.
package shifter_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_LSL = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LSR = 3'b001;
  localparam logic [MODE_W-1:0] MODE_ASR = 3'b010;
  localparam logic [MODE_W-1:0] MODE_ROL = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROR = 3'b100;

  function automatic logic is_right(input logic [MODE_W-1:0] mode);
    return (mode == MODE_LSR) || (mode == MODE_ASR) ||
           (mode == MODE_ROR);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One 2^K step of the barrel shifter: shift, guard/sticky update,
// stage register and valid/ready handshake.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3,
  parameter int K     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SHW-1:0]    in_shift,
  input  logic [MODE_W-1:0] in_mode,
  input  logic              in_guard,
  input  logic              in_sticky,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [SHW-1:0]    out_shift,
  output logic [MODE_W-1:0] out_mode,
  output logic              out_guard,
  output logic              out_sticky
);

  localparam int S = 1 << K;
  localparam logic [WIDTH-1:0] LOW_MASK =
    WIDTH'((64'd1 << (S - 1)) - 64'd1);

  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SHW-1:0]    shift_q, shift_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              guard_q, guard_d;
  logic              sticky_q, sticky_d;
  logic [WIDTH-1:0]  shifted;
  logic              gs_en;
  logic              load;

  assign in_ready = !valid_q || out_ready;
  assign load     = in_ready && in_valid;

  always_comb begin
    valid_d = in_ready ? in_valid : valid_q;
  end

  always_comb begin
    shifted = in_data;
    unique case (1'b1)
      in_mode == MODE_LSL: shifted = in_data << S;
      in_mode == MODE_LSR: shifted = in_data >> S;
      in_mode == MODE_ASR:
        shifted = $unsigned($signed(in_data) >>> S);
      in_mode == MODE_ROL:
        shifted = (in_data << S) | (in_data >> (WIDTH - S));
      in_mode == MODE_ROR:
        shifted = (in_data >> S) | (in_data << (WIDTH - S));
      default: shifted = in_data;
    endcase
  end

  // guard/sticky only carry meaning for bits lost off the LSB end
  assign gs_en = is_right(in_mode) && (in_mode != MODE_ROR);

  always_comb begin
    data_d   = in_shift[K] ? shifted : in_data;
    shift_d  = in_shift;
    mode_d   = in_mode;
    guard_d  = 1'b0;
    sticky_d = 1'b0;
    if (gs_en) begin
      if (in_shift[K]) begin
        guard_d  = in_data[S-1];
        sticky_d = in_sticky || in_guard ||
                   (|(in_data & LOW_MASK));
      end else begin
        guard_d  = in_guard;
        sticky_d = in_sticky;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  if (K == SHW - 1) begin : g_out_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q   <= '0;
        shift_q  <= '0;
        mode_q   <= '0;
        guard_q  <= 1'b0;
        sticky_q <= 1'b0;
      end else if (load) begin
        data_q   <= data_d;
        shift_q  <= shift_d;
        mode_q   <= mode_d;
        guard_q  <= guard_d;
        sticky_q <= sticky_d;
      end
    end
  end else begin : g_mid_reg
    always_ff @(posedge clk) begin
      if (load) begin
        data_q   <= data_d;
        shift_q  <= shift_d;
        mode_q   <= mode_d;
        guard_q  <= guard_d;
        sticky_q <= sticky_d;
      end
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_shift  = shift_q;
  assign out_mode   = mode_q;
  assign out_guard  = guard_q;
  assign out_sticky = sticky_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SHW chained shift_stage instances
// with a valid/ready stream on both ends.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SHW-1:0]    in_shift,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_guard,
  output logic              out_sticky
);

  logic              valid_w  [SHW+1];
  logic [WIDTH-1:0]  data_w   [SHW+1];
  logic [SHW-1:0]    shift_w  [SHW+1];
  logic [MODE_W-1:0] mode_w   [SHW+1];
  logic              guard_w  [SHW+1];
  logic              sticky_w [SHW+1];
  logic [SHW-1:0]    nxt_rdy;
  logic [SHW-1:0]    rdy_w;
  logic              unused_ctrl;

  assign valid_w[0]  = in_valid;
  assign data_w[0]   = in_data;
  assign shift_w[0]  = in_shift;
  assign mode_w[0]   = in_mode;
  assign guard_w[0]  = 1'b0;
  assign sticky_w[0] = 1'b0;

  // ready chain built from registered valids, so no comb loop
  always_comb begin
    logic acc;
    nxt_rdy = '0;
    acc     = out_ready;
    for (int i = SHW - 1; i >= 0; i--) begin
      nxt_rdy[i] = acc;
      acc        = acc || !valid_w[i+1];
    end
  end

  for (genvar i = 0; i < SHW; i++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .K     (i)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (valid_w[i]),
      .in_ready   (rdy_w[i]),
      .in_data    (data_w[i]),
      .in_shift   (shift_w[i]),
      .in_mode    (mode_w[i]),
      .in_guard   (guard_w[i]),
      .in_sticky  (sticky_w[i]),
      .out_valid  (valid_w[i+1]),
      .out_ready  (nxt_rdy[i]),
      .out_data   (data_w[i+1]),
      .out_shift  (shift_w[i+1]),
      .out_mode   (mode_w[i+1]),
      .out_guard  (guard_w[i+1]),
      .out_sticky (sticky_w[i+1])
    );
  end

  assign in_ready   = rdy_w[0];
  assign out_valid  = valid_w[SHW];
  assign out_data   = data_w[SHW];
  assign out_guard  = guard_w[SHW];
  assign out_sticky = sticky_w[SHW];

  assign unused_ctrl = ^{rdy_w[SHW-1:1], shift_w[SHW], mode_w[SHW]};

endmodule
